// File: rtl/bus_arb_if.sv
// Bus arbiter signal bundle: per-master request/lock/burst inputs, slave ready,
// and the grant outputs. The arbiter binds the slave modport, the requesters the master modport.
interface bus_arb_if;
  logic [2:0]  MxREQ;
  logic [2:0]  MxLK;
  logic [11:0] MxRB;
  logic        SxRDY;
  logic [3:0]  MxGNT;
  logic [1:0]  GNT_ID;
  logic        LAST;
  logic        BUSY;

  // Handshake: a beat completes on a rising CLK edge where the bus is owned (BUSY=1)
  // and SxRDY=1; with SxRDY=0 the owner, beat counter and lock count all hold.
  modport slave (
    input  MxREQ, MxLK, MxRB, SxRDY,
    output MxGNT, GNT_ID, LAST, BUSY
  );

  modport master (
    output MxREQ, MxLK, MxRB, SxRDY,
    input  MxGNT, GNT_ID, LAST, BUSY
  );
endinterface

// File: rtl/bus_arb.sv
// Three-master bus arbiter with burst counting, bounded lock re-grants and a parked default master.
// Define BUS_ARB_FIXED_PRIO_EN for fixed priority (0 > 1 > 2) instead of round-robin.
module bus_arb #(
  parameter int LOCK_MAX = 8
) (
  input  logic      CLK,
  input  logic      RST,
  bus_arb_if.slave  bus,
  output logic      state_dbg
);

  typedef enum logic {PARK = 1'b0, XFER = 1'b1} state_t;

  state_t     state, state_n;
  logic [1:0] owner, owner_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] lock_cnt, lock_cnt_n;
  logic [2:0] owner_bit;
  logic [2:0] cand;
  logic [1:0] winner;
  logic       lock_ok;
  logic       lock_spent;
`ifndef BUS_ARB_FIXED_PRIO_EN
  logic [1:0] last_owner, last_owner_n;
`endif

  function automatic logic [3:0] rb_of(input logic [11:0] rb, input logic [1:0] idx);
    case (idx)
      2'd0:    rb_of = rb[3:0];
      2'd1:    rb_of = rb[7:4];
      default: rb_of = rb[11:8];
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= PARK;
      owner      <= 2'd0;
      cnt        <= 4'd0;
      lock_cnt   <= 4'd0;
`ifndef BUS_ARB_FIXED_PRIO_EN
      last_owner <= 2'd2;
`endif
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      cnt        <= cnt_n;
      lock_cnt   <= lock_cnt_n;
`ifndef BUS_ARB_FIXED_PRIO_EN
      last_owner <= last_owner_n;
`endif
    end
  end

  // Candidate set: an owner that used up its lock budget steps aside only if someone else waits.
  always_comb begin
    owner_bit  = 3'b001 << owner;
    lock_spent = (lock_cnt >= 4'(LOCK_MAX));
    lock_ok    = ((bus.MxLK & owner_bit) != 3'b000) && ((bus.MxREQ & owner_bit) != 3'b000) &&
                 (lock_cnt < 4'(LOCK_MAX));
    cand       = bus.MxREQ;
    if (state == XFER && lock_spent && ((bus.MxREQ & ~owner_bit) != 3'b000))
      cand = bus.MxREQ & ~owner_bit;
  end

  always_comb begin
    winner = 2'd0;
`ifdef BUS_ARB_FIXED_PRIO_EN
    if (cand[0])      winner = 2'd0;
    else if (cand[1]) winner = 2'd1;
    else              winner = 2'd2;
`else
    case (last_owner)
      2'd0:    winner = cand[1] ? 2'd1 : (cand[2] ? 2'd2 : 2'd0);
      2'd1:    winner = cand[2] ? 2'd2 : (cand[0] ? 2'd0 : 2'd1);
      default: winner = cand[0] ? 2'd0 : (cand[1] ? 2'd1 : 2'd2);
    endcase
`endif
  end

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    cnt_n        = cnt;
    lock_cnt_n   = lock_cnt;
`ifndef BUS_ARB_FIXED_PRIO_EN
    last_owner_n = last_owner;
`endif
    case (state)
      PARK: begin
        if (cand != 3'b000) begin
          state_n      = XFER;
          owner_n      = winner;
          cnt_n        = rb_of(bus.MxRB, winner);
`ifndef BUS_ARB_FIXED_PRIO_EN
          last_owner_n = winner;
`endif
        end
      end
      default: begin
        if (bus.SxRDY) begin
          if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
          end else if (lock_ok) begin
            cnt_n        = rb_of(bus.MxRB, owner);
            lock_cnt_n   = lock_cnt + 4'd1;
`ifndef BUS_ARB_FIXED_PRIO_EN
            last_owner_n = owner;
`endif
          end else begin
            lock_cnt_n = 4'd0;
            if (cand != 3'b000) begin
              owner_n      = winner;
              cnt_n        = rb_of(bus.MxRB, winner);
`ifndef BUS_ARB_FIXED_PRIO_EN
              last_owner_n = winner;
`endif
            end else begin
              state_n = PARK;
              cnt_n   = 4'd0;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    state_dbg  = state;
    bus.BUSY   = (state == XFER);
    bus.MxGNT  = (state == XFER) ? (4'b0001 << owner) : 4'b1000;
    bus.GNT_ID = (state == XFER) ? owner : 2'd3;
    bus.LAST   = (state == XFER) && (cnt == 4'd0);
  end

endmodule

// File: tb/tb_bus_arb.sv
// Randomized and directed bench for bus_arb against a burst-level reference model.
module tb_bus_arb;
  localparam int LOCK_MAX = 8;

  logic CLK;
  logic RST;
  logic state_dbg;
  int   checks = 0;
  int   errors = 0;

  bus_arb_if bus();

  bus_arb #(.LOCK_MAX(LOCK_MAX)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: owner (3 = parked), beats still to go after the current one,
  // locked re-grants taken so far, and the most recent grantee.
  int m_own  = 3;
  int m_left = 0;
  int m_lock = 0;
  int m_prev = 2;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [2:0] req, input int prev);
`ifdef BUS_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) if (req[i]) return i;
`else
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (prev + k) % 3;
      if (req[i]) return i;
    end
`endif
    return 3;
  endfunction

  task automatic m_grant(input int w, input logic [11:0] rb);
    m_own  = w;
    m_left = int'((rb >> (4 * w)) & 12'hF);
    m_prev = w;
  endtask

  task automatic m_update(input logic [2:0] req, input logic [2:0] lk,
                          input logic [11:0] rb, input logic rdy, input logic rst);
    logic [2:0] others;
    logic [2:0] cands;
    if (rst) begin
      m_own = 3; m_left = 0; m_lock = 0; m_prev = 2;
    end else if (m_own == 3) begin
      if (req != 3'b000) m_grant(m_pick(req, m_prev), rb);
    end else if (rdy) begin
      if (m_left > 0) begin
        m_left--;
      end else if (lk[m_own] && req[m_own] && m_lock < LOCK_MAX) begin
        m_left = int'((rb >> (4 * m_own)) & 12'hF);
        m_lock++;
        m_prev = m_own;
      end else begin
        others = req;
        others[m_own] = 1'b0;
        cands = (m_lock >= LOCK_MAX && others != 3'b000) ? others : req;
        m_lock = 0;
        if (cands != 3'b000) m_grant(m_pick(cands, m_prev), rb);
        else begin
          m_own = 3; m_left = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then compare on the falling edge.
  task automatic step(input logic [2:0] req, input logic [2:0] lk, input logic [11:0] rb,
                      input logic rdy, input logic rst);
    logic [3:0] exp_gnt;
    bus.MxREQ = req;
    bus.MxLK  = lk;
    bus.MxRB  = rb;
    bus.SxRDY = rdy;
    RST       = rst;
    m_update(req, lk, rb, rdy, rst);
    @(posedge CLK);
    @(negedge CLK);
    exp_gnt = 4'b0001 << m_own;
    check("gnt", 8'(bus.MxGNT), 8'(exp_gnt));
    check("gnt_id", 8'(bus.GNT_ID), 8'(m_own));
    check("busy", 8'(bus.BUSY), 8'(m_own != 3));
    check("last", 8'(bus.LAST), 8'(m_own != 3 && m_left == 0));
    check("state_dbg", 8'(state_dbg), 8'(m_own != 3));
    check("onehot", 8'($onehot(bus.MxGNT)), 8'd1);
  endtask

  initial begin
    int n;
    logic [11:0] rb;
    bus.MxREQ = 3'b000; bus.MxLK = 3'b000; bus.MxRB = 12'h000; bus.SxRDY = 1'b0; RST = 1'b1;
    step(3'b000, 3'b000, 12'h000, 1'b0, 1'b1);
    step(3'b000, 3'b000, 12'h000, 1'b1, 1'b1);

    // Back-to-back single-beat bursts from all three masters.
    for (int k = 0; k < 7; k++) begin
      step(3'b111, 3'b000, 12'h000, 1'b1, 1'b0);
`ifdef BUS_ARB_FIXED_PRIO_EN
      check("fixed_seq", 8'(bus.GNT_ID), 8'd0);
`else
      check("rr_seq", 8'(bus.GNT_ID), 8'(k % 3));
`endif
    end
    step(3'b000, 3'b000, 12'h000, 1'b1, 1'b0);
    check("park_after_rr", 8'(bus.MxGNT), 8'h08);

    // Lone 4-beat burst under a toggling ready.
    step(3'b010, 3'b000, 12'h030, 1'b1, 1'b0);
    n = (bus.MxGNT == 4'b0010) ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      step(3'b000, 3'b000, 12'h030, (k % 2) == 0, 1'b0);
      if (bus.MxGNT == 4'b0010) n++;
      else break;
    end
    check("m1_grant_cycles", 8'(n), 8'd7);
    check("m1_then_park", 8'(bus.BUSY), 8'd0);

    // Locked master 2 against a competing master 0.
    step(3'b100, 3'b100, 12'h000, 1'b1, 1'b0);
    n = (bus.GNT_ID == 2'd2) ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      step(3'b101, 3'b100, 12'h000, 1'b1, 1'b0);
      if (bus.GNT_ID == 2'd2) n++;
      else break;
    end
    check("lock_beats", 8'(n), 8'(LOCK_MAX + 1));
    check("lock_handoff", 8'(bus.GNT_ID), 8'd0);
    step(3'b000, 3'b000, 12'h000, 1'b1, 1'b0);

    // Reset in the middle of a 4-beat burst.
    step(3'b001, 3'b000, 12'h003, 1'b1, 1'b0);
    step(3'b001, 3'b000, 12'h003, 1'b1, 1'b0);
    step(3'b001, 3'b000, 12'h003, 1'b1, 1'b0);
    step(3'b001, 3'b000, 12'h003, 1'b1, 1'b1);
    check("rst_gnt", 8'(bus.MxGNT), 8'h08);
    check("rst_busy", 8'(bus.BUSY), 8'd0);
    step(3'b001, 3'b000, 12'h003, 1'b1, 1'b0);
    check("regrant_id", 8'(bus.GNT_ID), 8'd0);
    check("regrant_last", 8'(bus.LAST), 8'd0);
    repeat (4) step(3'b000, 3'b000, 12'h003, 1'b1, 1'b0);
    check("drain_park", 8'(bus.BUSY), 8'd0);

    // Requester drops out after the first beat of a 3-beat burst.
    step(3'b001, 3'b000, 12'h002, 1'b1, 1'b0);
    step(3'b000, 3'b000, 12'h002, 1'b1, 1'b0);
    check("drop_held", 8'(bus.MxGNT), 8'h01);
    step(3'b000, 3'b000, 12'h002, 1'b1, 1'b0);
    check("drop_last", 8'(bus.LAST), 8'd1);
    step(3'b000, 3'b000, 12'h002, 1'b1, 1'b0);
    check("drop_park", 8'(bus.MxGNT), 8'h08);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      rb = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rb,
           $urandom_range(0, 9) < 7, $urandom_range(0, 63) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 The module SHALL have parameter LOCK_MAX, default 8, meaning the maximum number of consecutive locked transfers one master may hold before forced re-arbitration (range 1..15).
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The module SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port MxREQ, input, 3 bits: request from masters 0..2, one bit per master.
REQ-005 The module SHALL have port MxLK, input, 3 bits: lock request per master; 1 means a locked (indivisible) transfer.
REQ-006 The module SHALL have port MxRB, input, 12 bits: burst length per master, 4 bits each, master n at [4n+3:4n]; beats = MxRB+1.
REQ-007 The module SHALL have port SxRDY, input, 1 bit: the addressed slave accepts the current beat.
REQ-008 The module SHALL have port MxGNT, output, 4 bits: one-hot grant; bit 3 is the default master (parked bus).
REQ-009 The module SHALL have port GNT_ID, output, 2 bits: encoded owner 0..3, where 3 is the default master.
REQ-010 The module SHALL have port LAST, output, 1 bit: the current beat is the final beat of the owner's burst.
REQ-011 The module SHALL have port BUSY, output, 1 bit: a real master (0..2) owns the bus.

Function
REQ-012 The arbiter SHALL have two states. PARK: MxGNT=4'b1000, GNT_ID=3, BUSY=0, LAST=0. XFER: a master owns the bus, BUSY=1.
REQ-013 In PARK with MxREQ!=0, the arbiter SHALL select a winner and, on the next edge, enter XFER with MxGNT=1<<winner and beat counter=MxRB[winner]; this is 1-cycle request-to-grant latency.
REQ-014 In PARK with MxREQ=0, the arbiter SHALL stay in PARK.
REQ-015 Winner selection SHALL be round-robin: search order starts at (LAST_OWNER+1) mod 3 and wraps, so the previous owner has lowest priority.
REQ-016 LAST_OWNER SHALL update on every new grant, including a re-grant under lock.
REQ-017 In XFER, each cycle with SxRDY=1 SHALL decrement the counter; SxRDY=0 SHALL hold all state.
REQ-018 LAST SHALL equal 1 when in XFER and the counter is 0; this is combinational from state.
REQ-019 Burst end is LAST=1 and SxRDY=1. At burst end with MxLK[owner]=1, MxREQ[owner]=1 and lock count<LOCK_MAX, the arbiter SHALL keep the owner, reload the counter from MxRB[owner], and increment the lock count.
REQ-020 At any other burst end, the arbiter SHALL clear the lock count and re-arbitrate in the same edge: if any MxREQ is set, grant the round-robin winner directly (no PARK cycle between owners); otherwise enter PARK.
REQ-021 When the lock count reaches LOCK_MAX, the owner SHALL be excluded from that arbitration only if another master requests; if none requests, the owner SHALL be re-granted and the lock count reset to 0.
REQ-022 Deassertion of MxREQ[owner] mid-burst SHALL be ignored; the burst completes.
REQ-023 MxREQ/MxLK/MxRB changes by the owner mid-burst SHALL be ignored; MxRB is sampled only at grant or reload.
REQ-024 MxGNT SHALL always be exactly one-hot; two masters SHALL never be granted simultaneously.
REQ-025 The beat counter SHALL be 4 bits and SHALL never wrap below 0; decrement occurs only when the counter is >0.

Reset
REQ-026 While RST=1 at a clock edge, the arbiter SHALL reset to PARK with MxGNT=4'b1000, GNT_ID=2'd3, BUSY=0, LAST=0, counter=0, lock count=0, LAST_OWNER=2 (so master 0 wins first).
REQ-027 RST asserted mid-burst SHALL abort the burst; the outputs SHALL show reset values on the cycle after the edge.

Configuration
REQ-028 With macro BUS_ARB_FIXED_PRIO_EN defined, winner selection SHALL be fixed priority (master 0 > 1 > 2), LAST_OWNER SHALL be unused, and all other rules SHALL be unchanged.
REQ-029 Without BUS_ARB_FIXED_PRIO_EN, winner selection SHALL be round-robin per REQ-015.

Verification
REQ-030 Reset release, MxREQ=3'b111, all MxRB=0, SxRDY=1 -> grants 0,1,2,0,... one per cycle, MxGNT never 4'b1000 between them.
REQ-031 M1 alone, MxRB[1]=3, SxRDY toggling 1,0,1,0,... -> MxGNT=4'b0010 for 7 cycles, LAST high only on the final SxRDY=1 beat, then PARK.
REQ-032 M2 locked with MxRB=0, M0 also requesting, LOCK_MAX=8 -> M2 holds 9 consecutive beats (initial plus 8 locked re-grants), then M0 is granted.
REQ-033 RST=1 pulsed on beat 2 of a 4-beat M0 burst -> next cycle MxGNT=4'b1000, BUSY=0, and M0 is re-granted from beat 0 after release.
REQ-034 M0 drops MxREQ after beat 0 of a 3-beat burst -> grant held until LAST with SxRDY=1, then PARK.
REQ-035 With BUS_ARB_FIXED_PRIO_EN, MxREQ=3'b111 and MxRB=0 continuously -> M0 granted every burst; M1 and M2 are never granted.
